// File: rtl/fast_arc_scheduler_if.sv
// Candidate/result bus of the FAST segment-test scheduler.
// The slave side is the scheduler. The master side is the ring-window generator,
// the arc detector and the score/NMS stage taken together.
interface fast_arc_scheduler_if #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned CNT_W = 16
);
   logic                  i_valid;
   logic                  o_ready;
   logic [PIX_W-1:0]      i_center;
   logic [16*PIX_W-1:0]   i_ring;
   logic [PIX_W-1:0]      i_threshold;
   logic [15:0]           o_arc_value;
   logic                  i_arc_valid;
   logic                  o_valid;
   logic                  o_is_kp;
   logic                  o_bright;
   logic [CNT_W-1:0]      o_kp_count;
   logic                  o_busy;

   modport master (
      output i_valid, i_center, i_ring, i_threshold, i_arc_valid,
      input  o_ready, o_arc_value, o_valid, o_is_kp, o_bright, o_kp_count, o_busy
   );

   modport slave (
      input  i_valid, i_center, i_ring, i_threshold, i_arc_valid,
      output o_ready, o_arc_value, o_valid, o_is_kp, o_bright, o_kp_count, o_busy
   );
endinterface

// File: rtl/fast_arc_scheduler.sv
// FAST segment-test sequencer.
// On accept it builds the bright and dark ring masks. It then time-shares one
// external 16-bit arc detector between the two masks, and reports the
// keypoint/polarity result with a running keypoint count.
// Optional feature: define FAST_EARLY_REJECT_EN to enable a compass pre-test on
// pixels 0/4/8/12. A candidate that fails the pre-test skips the detector.
module fast_arc_scheduler #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned CNT_W = 16
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   fast_arc_scheduler_if.slave bus
);
   typedef enum logic [2:0] {StIdle, StIssueB, StIssueD, StCaptD, StDone} state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [15:0]      r_bright_mask;
   logic [15:0]      r_dark_mask;
   logic [15:0]      w_bright_mask;
   logic [15:0]      w_dark_mask;
   logic             r_bright_res;
   logic             r_dark_res;
   logic [CNT_W-1:0] r_kp_count;
   logic [PIX_W:0]   w_hi_sum;
   logic [PIX_W:0]   w_lo_diff;
   logic             w_accept;
   logic             w_reject;

   assign w_accept  = bus.i_valid & (r_state == StIdle);
   assign w_hi_sum  = {1'b0, bus.i_center} + {1'b0, bus.i_threshold};
   assign w_lo_diff = {1'b0, bus.i_center} - {1'b0, bus.i_threshold};

   // Ring compare against the thresholds. No pixel can exceed a saturated hi, so
   // comparing against the unclamped sum gives the same result as min(). A borrow
   // out of c-t means lo clamps to 0, and then no pixel is dark.
   always_comb begin
      w_bright_mask = '0;
      w_dark_mask   = '0;
      for (int k = 0; k < 16; k++) begin
         w_bright_mask[k] = {1'b0, bus.i_ring[PIX_W*k +: PIX_W]} > w_hi_sum;
         w_dark_mask[k]   = !w_lo_diff[PIX_W] &&
                            ({1'b0, bus.i_ring[PIX_W*k +: PIX_W]} < w_lo_diff);
      end
   end

`ifdef FAST_EARLY_REJECT_EN
   logic [2:0] w_cmp_bright;
   logic [2:0] w_cmp_dark;

   // Any 9-arc covers at least two compass pixels, so fewer than two on both
   // polarities means no keypoint is possible.
   always_comb begin
      w_cmp_bright = {2'b0, w_bright_mask[0]} + {2'b0, w_bright_mask[4]} +
                     {2'b0, w_bright_mask[8]} + {2'b0, w_bright_mask[12]};
      w_cmp_dark   = {2'b0, w_dark_mask[0]} + {2'b0, w_dark_mask[4]} +
                     {2'b0, w_dark_mask[8]} + {2'b0, w_dark_mask[12]};
   end

   assign w_reject = (w_cmp_bright < 3'd2) && (w_cmp_dark < 3'd2);
`else
   assign w_reject = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= StIdle;
      else          r_state <= w_state_next;
   end

   // Next-state: fixed walk through both detector slots, one result cycle
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:   if (bus.i_valid) w_state_next = w_reject ? StDone : StIssueB;
         StIssueB: w_state_next = StIssueD;
         StIssueD: w_state_next = StCaptD;
         StCaptD:  w_state_next = StDone;
         StDone:   w_state_next = StIdle;
         default:  w_state_next = StIdle;
      endcase
   end

   // Detector drive: bright mask first, dark mask second, zero otherwise
   always_comb begin
      bus.o_arc_value = '0;
      case (r_state)
         StIssueB: bus.o_arc_value = r_bright_mask;
         StIssueD: bus.o_arc_value = r_dark_mask;
         default:  bus.o_arc_value = '0;
      endcase
   end

   assign bus.o_ready    = (r_state == StIdle);
   assign bus.o_busy     = (r_state != StIdle);
   assign bus.o_valid    = (r_state == StDone);
   assign bus.o_is_kp    = (r_state == StDone) & (r_bright_res | r_dark_res);
   assign bus.o_bright   = (r_state == StDone) & r_bright_res;
   assign bus.o_kp_count = r_kp_count;

   // Masks are latched on accept. Detector results arrive one cycle after each mask.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_bright_mask <= '0;
         r_dark_mask   <= '0;
         r_bright_res  <= 1'b0;
         r_dark_res    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_bright_mask <= w_bright_mask;
            r_dark_mask   <= w_dark_mask;
            r_bright_res  <= 1'b0;
            r_dark_res    <= 1'b0;
         end
         if (r_state == StIssueD) r_bright_res <= bus.i_arc_valid;
         if (r_state == StCaptD)  r_dark_res   <= bus.i_arc_valid;
      end
   end

   // Keypoint counter, wraps naturally
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                                        r_kp_count <= '0;
      else if (r_state == StDone && (r_bright_res | r_dark_res)) r_kp_count <= r_kp_count + 1'b1;
   end
endmodule

// File: tb/tb_fast_arc_scheduler.sv
// Scoreboard bench for fast_arc_scheduler.
// The stimulus side computes expected masks, results and latency from the pixel
// rules and queues them. The monitor checks DUT outputs every cycle against
// those expectations. The arc detector is modelled as a registered circular
// run-length test.
// Honours FAST_EARLY_REJECT_EN for the expected latency.
module tb_fast_arc_scheduler;
   localparam int PIX = 8;
   localparam int CNT = 16;

   typedef struct {
      int n;
      int lat;
      bit kp;
      bit br;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_pass;
   bit   rst_edge;
   exp_t q[$];
   logic [15:0] exp_arc [int];
   logic [CNT-1:0] exp_count;

   fast_arc_scheduler_if #(.PIX_W(PIX), .CNT_W(CNT)) bus ();

   fast_arc_scheduler #(.PIX_W(PIX), .CNT_W(CNT)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // True if mask m has a circular run of at least 9 ones
   function automatic bit has_arc(input logic [15:0] m);
      for (int s = 0; s < 16; s++) begin
         int run = 0;
         for (int j = 0; j < 16; j++) begin
            if (m[(s + j) % 16]) run++;
            else break;
         end
         if (run >= 9) return 1'b1;
      end
      return 1'b0;
   endfunction

   // External detector with one-cycle registered latency
   always @(posedge clk) bus.i_arc_valid <= has_arc(bus.o_arc_value);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void model(input int c, input int t, input int ring[16],
                                 output logic [15:0] bm, output logic [15:0] dm,
                                 output bit kp, output bit br, output int lat);
      int hi = (c + t > 255) ? 255 : c + t;
      int lo = (c - t < 0) ? 0 : c - t;
      int nb = 0;
      int nd = 0;
      for (int k = 0; k < 16; k++) begin
         bm[k] = ring[k] > hi;
         dm[k] = ring[k] < lo;
      end
      br = has_arc(bm);
      kp = br | has_arc(dm);
      for (int k = 0; k < 16; k += 4) begin
         nb += int'(bm[k]);
         nd += int'(dm[k]);
      end
`ifdef FAST_EARLY_REJECT_EN
      lat = (nb < 2 && nd < 2) ? 1 : 4;
`else
      lat = 4;
`endif
   endfunction

   task automatic drive(input int c, input int t, input int ring[16]);
      bus.i_center    = PIX'(c);
      bus.i_threshold = PIX'(t);
      for (int k = 0; k < 16; k++) bus.i_ring[PIX*k +: PIX] = PIX'(ring[k]);
      bus.i_valid = 1'b1;
   endtask

   // Present a candidate, wait for acceptance, and queue its expected response.
   // Leaves i_valid high, so that a following call runs back-to-back.
   task automatic send(input int c, input int t, input int ring[16]);
      logic [15:0] bm, dm;
      bit kp, br, acc;
      int lat;
      model(c, t, ring, bm, dm, kp, br, lat);
      drive(c, t, ring);
      acc = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
         @(negedge clk);
         if (bus.o_ready) begin
            acc = 1'b1;
            q.push_back('{n: cyc, lat: lat, kp: kp, br: br});
            if (lat == 4) begin
               exp_arc[cyc + 1] = bm;
               exp_arc[cyc + 2] = dm;
            end
         end
      end
      check("accept", 32'(acc), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.i_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_cand(output int c, output int t, output int ring[16]);
      int mode, len, st, v;
      c    = int'($urandom_range(0, 255));
      t    = int'($urandom_range(1, 60));
      mode = int'($urandom_range(0, 2));
      len  = int'($urandom_range(6, 16));
      st   = int'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) begin
         v = c + int'($urandom_range(0, 2 * t)) - t;
         ring[k] = (v < 0) ? 0 : (v > 255) ? 255 : v;
      end
      for (int j = 0; j < len; j++) begin
         if (mode == 0)
            ring[(st + j) % 16] = int'($urandom_range((c + t + 1 > 255) ? 255 : c + t + 1, 255));
         else if (mode == 1)
            ring[(st + j) % 16] = int'($urandom_range(0, (c - t - 1 < 0) ? 0 : c - t - 1));
         else
            ring[(st + j) % 16] = int'($urandom_range(0, 255));
      end
   endtask

   // Monitor. At each posedge it advances the cycle count and applies reset to the
   // model. At each negedge it compares every output with the scoreboard.
   initial begin
      exp_t e;
      logic [15:0] exp_a;
      bit exp_busy;
      cyc = 0;
      exp_count = '0;
      forever begin
         @(posedge clk);
         cyc++;
         rst_edge = !rst_n;
         if (rst_edge) begin
            q.delete();
            exp_arc.delete();
            exp_count = '0;
         end
         @(negedge clk);
         if (rst_edge) begin
            check("rst_ready", 32'(bus.o_ready), 32'd1);
            check("rst_valid", 32'(bus.o_valid), 32'd0);
            check("rst_busy", 32'(bus.o_busy), 32'd0);
            check("rst_arc", 32'(bus.o_arc_value), 32'd0);
            check("rst_count", 32'(bus.o_kp_count), 32'd0);
         end else begin
            exp_a = exp_arc.exists(cyc) ? exp_arc[cyc] : 16'h0;
            check("arc_value", 32'(bus.o_arc_value), 32'(exp_a));
            exp_busy = (q.size() > 0) && (cyc > q[0].n);
            check("busy", 32'(bus.o_busy), 32'(exp_busy));
            check("ready", 32'(bus.o_ready), 32'(!exp_busy));
            check("kp_count", 32'(bus.o_kp_count), 32'(exp_count));
            if (q.size() > 0 && cyc == q[0].n + q[0].lat) begin
               e = q.pop_front();
               check("valid", 32'(bus.o_valid), 32'd1);
               check("is_kp", 32'(bus.o_is_kp), 32'(e.kp));
               if (e.kp) begin
                  check("bright", 32'(bus.o_bright), 32'(e.br));
                  exp_count = exp_count + 1'b1;
               end
            end else begin
               check("valid", 32'(bus.o_valid), 32'd0);
            end
         end
      end
   end

   // Stimulus
   initial begin
      int ring[16];
      int c, t;
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_center = '0;
      bus.i_threshold = '0;
      bus.i_ring = '0;

      // Reset held with a bright candidate already presented
      for (int k = 0; k < 16; k++) ring[k] = (k >= 3 && k <= 11) ? 200 : 100;
      drive(100, 20, ring);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(100, 20, ring);
      idle(6);

      // Dark arc wrapping through pixel 0
      for (int k = 0; k < 16; k++) ring[k] = (k >= 12 || k <= 4) ? 50 : 100;
      send(100, 10, ring);
      idle(5);

      // hi saturates: nothing can be bright
      for (int k = 0; k < 16; k++) ring[k] = 255;
      send(250, 10, ring);
      idle(5);

      // 8-arc only
      for (int k = 0; k < 16; k++) ring[k] = (k <= 7) ? 200 : 100;
      send(100, 20, ring);
      idle(5);

      // Pixel equal to c+t is not bright
      for (int k = 0; k < 16; k++) ring[k] = 120;
      send(100, 20, ring);
      idle(5);

      // Flat ring, rejected early when the pre-test is enabled
      for (int k = 0; k < 16; k++) ring[k] = 100;
      send(100, 20, ring);
      idle(5);

      // 10-arc of full-scale pixels
      for (int k = 0; k < 16; k++) ring[k] = (k >= 6) ? 255 : 0;
      send(128, 30, ring);
      idle(5);

      // Back-to-back with i_valid held high
      for (int i = 0; i < 5; i++) begin
         rand_cand(c, t, ring);
         send(c, t, ring);
      end
      idle(6);

      // Reset while the dark mask is being issued
      for (int k = 0; k < 16; k++) ring[k] = (k >= 3 && k <= 11) ? 200 : 100;
      send(100, 20, ring);
      bus.i_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(8);

      // Randomized candidates with random gaps
      for (int i = 0; i < 60; i++) begin
         rand_cand(c, t, ring);
         send(c, t, ring);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 3)));
      end
      idle(2);

      for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
      @(negedge clk);
      check("drain", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
